psr_cond_unit: RTL and testbench

PSR_COND_UNIT -- requirements
Module: psr_cond_unit

---
 rtl/psr_cond_unit_pkg.sv | 39 +++
 rtl/psr_cond_unit_cond_eval.sv | 52 +++++
 rtl/psr_cond_unit.sv | 125 ++++++++++++
 tb/tb_psr_cond_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psr_cond_unit_pkg.sv
// Shared definitions for the PSR / condition-evaluation slice: flag bit
// positions inside the {Z,C,F,N,L} vector, default widths, the 16-entry
// condition-code enumeration and the output-register state constants.
package psr_cond_unit_pkg;

  localparam int FLAG_W_DEFAULT = 5;
  localparam int CC_W_DEFAULT   = 4;

  // Flag bit indices within the flag vector.
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,
    CC_NE = 4'd1,
    CC_CS = 4'd2,
    CC_CC = 4'd3,
    CC_HI = 4'd4,
    CC_LS = 4'd5,
    CC_GT = 4'd6,
    CC_LE = 4'd7,
    CC_FS = 4'd8,
    CC_FC = 4'd9,
    CC_LO = 4'd10,
    CC_HS = 4'd11,
    CC_LT = 4'd12,
    CC_GE = 4'd13,
    CC_UC = 4'd14,
    CC_NV = 4'd15
  } cond_code_e;

  // Output register occupancy.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// Purely combinational condition evaluator: maps a flag vector and a
// condition code onto a single taken bit.
module cond_eval
  import psr_cond_unit_pkg::*;
#(
  parameter int FLAG_W = FLAG_W_DEFAULT,
  parameter int CC_W   = CC_W_DEFAULT
) (
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [CC_W-1:0]   code_i,
  output logic              taken_o
);

  logic       flagZ;
  logic       flagC;
  logic       flagF;
  logic       flagN;
  logic       flagL;
  cond_code_e code;

  assign flagZ = flags_i[FLAG_Z];
  assign flagC = flags_i[FLAG_C];
  assign flagF = flags_i[FLAG_F];
  assign flagN = flags_i[FLAG_N];
  assign flagL = flags_i[FLAG_L];
  assign code  = cond_code_e'(code_i[3:0]);

  // Decode the condition code into the selected flag expression.
  always_comb begin
    taken_o = 1'b0;
    case (code)
      CC_EQ: taken_o = flagZ;
      CC_NE: taken_o = !flagZ;
      CC_CS: taken_o = flagC;
      CC_CC: taken_o = !flagC;
      CC_HI: taken_o = flagL;
      CC_LS: taken_o = !flagL;
      CC_GT: taken_o = flagN;
      CC_LE: taken_o = !flagN;
      CC_FS: taken_o = flagF;
      CC_FC: taken_o = !flagF;
      CC_LO: taken_o = !flagL && !flagZ;
      CC_HS: taken_o = flagL || flagZ;
      CC_LT: taken_o = !flagN && !flagZ;
      CC_GE: taken_o = flagN || flagZ;
      CC_UC: taken_o = 1'b1;
      CC_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// Processor status register with masked flag writes and a condition
// evaluation pipeline stage behind a valid/ready handshake. Evaluation
// sees the flag value being written in the same cycle (forwarding).
// Optional interrupt shadow register enabled by defining PSR_SHADOW_EN;
// without it, save/restore are accepted but ignored.
module psr_cond_unit
  import psr_cond_unit_pkg::*;
#(
  parameter int FLAG_W = FLAG_W_DEFAULT,
  parameter int CC_W   = CC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              cond_valid,
  output logic              cond_ready,
  input  logic [CC_W-1:0]   cond_code,
  output logic              taken_valid,
  input  logic              taken_ready,
  output logic              taken,
  output logic [FLAG_W-1:0] psr,
  input  logic              save,
  input  logic              restore
);

  logic [FLAG_W-1:0] psr_q;
  logic [FLAG_W-1:0] psr_d;
  logic [FLAG_W-1:0] psrWritten;
  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic              taken_q;
  logic              taken_d;
  logic              accept;
  logic              evalTaken;

  // Merge the ALU flags into the PSR only where the mask selects them.
  always_comb begin
    psrWritten = psr_q;
    if (flag_we) begin
      psrWritten = (psr_q & ~flag_mask) | (alu_flags & flag_mask);
    end
  end

`ifdef PSR_SHADOW_EN
  logic [FLAG_W-1:0] shadow_q;
  logic [FLAG_W-1:0] shadow_d;

  // Restore overrides any flag write; save captures the pre-update PSR so
  // a simultaneous save and restore swaps the two registers.
  always_comb begin
    psr_d    = restore ? shadow_q : psrWritten;
    shadow_d = save ? psr_q : shadow_q;
  end

  // Shadow register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  logic unused_shadow_strobes;
  assign unused_shadow_strobes = save ^ restore;

  // Without a shadow register the next PSR is just the masked write.
  always_comb begin
    psr_d = psrWritten;
  end
`endif

  cond_eval #(
    .FLAG_W (FLAG_W),
    .CC_W   (CC_W)
  ) u_cond_eval (
    .flags_i (psr_d),
    .code_i  (cond_code),
    .taken_o (evalTaken)
  );

  assign taken_valid = (state_q == ST_FULL);
  assign cond_ready  = !taken_valid || taken_ready;
  assign accept      = cond_valid && cond_ready;
  assign taken       = taken_q;
  assign psr         = psr_q;

  // Single-entry output register: refill on acceptance, drain on ready.
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (taken_ready && !accept) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      taken_d = evalTaken;
    end
  end

  // PSR, occupancy state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr_q   <= '0;
      state_q <= ST_EMPTY;
      taken_q <= 1'b0;
    end else begin
      psr_q   <= psr_d;
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: tb/tb_psr_cond_unit.sv
// Self-checking bench for psr_cond_unit. A behavioural model of the PSR,
// shadow and one-deep result buffer predicts every output; directed
// scenarios use hand-derived constants alongside the model.
module tb_psr_cond_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] alu_flags;
  logic       flag_we;
  logic [4:0] flag_mask;
  logic       cond_valid;
  logic       cond_ready;
  logic [3:0] cond_code;
  logic       taken_valid;
  logic       taken_ready;
  logic       taken;
  logic [4:0] psr;
  logic       save;
  logic       restore;

  int assertCount = 0;
  int failCount   = 0;

  logic [4:0] mPsr;
  logic [4:0] mShadow;
  bit         mValid;
  bit         mTaken;

  psr_cond_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_flags   (alu_flags),
    .flag_we     (flag_we),
    .flag_mask   (flag_mask),
    .cond_valid  (cond_valid),
    .cond_ready  (cond_ready),
    .cond_code   (cond_code),
    .taken_valid (taken_valid),
    .taken_ready (taken_ready),
    .taken       (taken),
    .psr         (psr),
    .save        (save),
    .restore     (restore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition truth table written from the named flags.
  function automatic bit refCond(input logic [4:0] f, input int code);
    bit z  = f[4];
    bit c  = f[3];
    bit fl = f[2];
    bit n  = f[1];
    bit l  = f[0];
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return l;
      5:  return !l;
      6:  return n;
      7:  return !n;
      8:  return fl;
      9:  return !fl;
      10: return !(l || z);
      11: return l || z;
      12: return !(n || z);
      13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    mPsr    = 5'b0;
    mShadow = 5'b0;
    mValid  = 1'b0;
    mTaken  = 1'b0;
  endtask

  task automatic setInputs(input bit cv, input int code, input bit we,
                           input logic [4:0] mask, input logic [4:0] alu,
                           input bit tr, input bit sv, input bit rs);
    cond_valid  = cv;
    cond_code   = code[3:0];
    flag_we     = we;
    flag_mask   = mask;
    alu_flags   = alu;
    taken_ready = tr;
    save        = sv;
    restore     = rs;
  endtask

  // Advance one clock; the model predicts from the inputs applied now.
  task automatic clockEdge();
    logic [4:0] nPsr;
    logic [4:0] nShadow;
    bit         acc;
    for (int i = 0; i < 5; i++) begin
      nPsr[i] = (flag_we && flag_mask[i]) ? alu_flags[i] : mPsr[i];
    end
    nShadow = mShadow;
`ifdef PSR_SHADOW_EN
    if (restore) nPsr = mShadow;
    if (save) nShadow = mPsr;
`endif
    acc = cond_valid && (!mValid || taken_ready);
    @(posedge clk);
    #1;
    if (acc) begin
      mValid = 1'b1;
      mTaken = refCond(nPsr, int'(cond_code));
    end else if (taken_ready) begin
      mValid = 1'b0;
    end
    mPsr    = nPsr;
    mShadow = nShadow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    assertCount++;
    if (psr !== 5'b0) begin failCount++; $display("[TB] FAIL reset_psr got %b want 00000", psr); end
    assertCount++;
    if (taken_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %b want 0", taken_valid); end
    assertCount++;
    if (taken !== 1'b0) begin failCount++; $display("[TB] FAIL reset_taken got %b want 0", taken); end
    assertCount++;
    if (cond_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready got %b want 1", cond_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    setInputs(1, 14, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b1 || taken !== 1'b1) begin
      failCount++; $display("[TB] FAIL first_accept got v=%b t=%b want v=1 t=1", taken_valid, taken);
    end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b0) begin failCount++; $display("[TB] FAIL drain_after_first got %b want 0", taken_valid); end
  endtask

  task automatic test_add_flags();
    setInputs(0, 0, 1, 5'b11111, 5'b00110, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (psr !== 5'b00110) begin failCount++; $display("[TB] FAIL add_psr got %b want 00110", psr); end
    setInputs(1, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b1 || taken !== 1'b0) begin
      failCount++; $display("[TB] FAIL add_eq got v=%b t=%b want v=1 t=0", taken_valid, taken);
    end
    setInputs(1, 8, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b1 || taken !== 1'b1) begin
      failCount++; $display("[TB] FAIL add_fs got v=%b t=%b want v=1 t=1", taken_valid, taken);
    end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
  endtask

  task automatic test_cmpu_mask();
    setInputs(0, 0, 1, 5'b10001, 5'b00001, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (psr !== 5'b00111) begin failCount++; $display("[TB] FAIL cmpu_psr got %b want 00111", psr); end
    assertCount++;
    if (psr[3:1] !== 3'b011) begin failCount++; $display("[TB] FAIL cmpu_cfn got %b want 011", psr[3:1]); end
    setInputs(1, 4, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken !== 1'b1) begin failCount++; $display("[TB] FAIL cmpu_hi got %b want 1", taken); end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
  endtask

  task automatic test_forwarding();
    setInputs(1, 0, 1, 5'b10000, 5'b10000, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b1 || taken !== 1'b1) begin
      failCount++; $display("[TB] FAIL fwd_eq got v=%b t=%b want v=1 t=1", taken_valid, taken);
    end
    assertCount++;
    if (psr !== mPsr) begin failCount++; $display("[TB] FAIL fwd_psr got %b want %b", psr, mPsr); end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
  endtask

  task automatic test_backpressure();
    int handshakes = 0;
    setInputs(1, 14, 0, 5'b0, 5'b0, 0, 0, 0);
    clockEdge();
    for (int i = 0; i < 3; i++) begin
      setInputs(1, 15, 0, 5'b0, 5'b0, 0, 0, 0);
      #1;
      assertCount++;
      if (cond_ready !== 1'b0) begin failCount++; $display("[TB] FAIL bp_ready cyc %0d got %b want 0", i, cond_ready); end
      if (taken_valid && taken_ready) handshakes++;
      clockEdge();
      assertCount++;
      if (taken_valid !== 1'b1 || taken !== 1'b1) begin
        failCount++; $display("[TB] FAIL bp_hold cyc %0d got v=%b t=%b want v=1 t=1", i, taken_valid, taken);
      end
    end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    #1;
    if (taken_valid && taken_ready) handshakes++;
    clockEdge();
    if (taken_valid && taken_ready) handshakes++;
    assertCount++;
    if (taken_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bp_drain got %b want 0", taken_valid); end
    assertCount++;
    if (handshakes !== 1) begin failCount++; $display("[TB] FAIL bp_count got %0d want 1", handshakes); end
  endtask

  task automatic test_shadow();
    logic [4:0] expPsr;
`ifdef PSR_SHADOW_EN
    expPsr = 5'b10000;
`else
    expPsr = 5'b00010;
`endif
    setInputs(0, 0, 1, 5'b11111, 5'b10000, 1, 0, 0);
    clockEdge();
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 1, 0);
    clockEdge();
    setInputs(0, 0, 1, 5'b11111, 5'b00010, 1, 0, 0);
    clockEdge();
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 1);
    clockEdge();
    assertCount++;
    if (psr !== expPsr) begin failCount++; $display("[TB] FAIL shadow_restore got %b want %b", psr, expPsr); end
    // Swap case, then restore again; the model decides the outcome.
    setInputs(0, 0, 1, 5'b11111, 5'b00001, 1, 0, 0);
    clockEdge();
    setInputs(0, 0, 1, 5'b11111, 5'b01000, 1, 1, 1);
    clockEdge();
    assertCount++;
    if (psr !== mPsr) begin failCount++; $display("[TB] FAIL shadow_swap got %b want %b", psr, mPsr); end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 1);
    clockEdge();
    assertCount++;
    if (psr !== mPsr) begin failCount++; $display("[TB] FAIL shadow_swap_back got %b want %b", psr, mPsr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      setInputs(1, int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                5'($urandom), 5'($urandom), 1, 0, 0);
      #1;
      assertCount++;
      if (cond_ready !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_ready cyc %0d got %b want 1", i, cond_ready); end
      clockEdge();
      assertCount++;
      if (taken_valid !== 1'b1 || taken !== mTaken) begin
        failCount++; $display("[TB] FAIL b2b_result cyc %0d got v=%b t=%b want v=1 t=%b", i, taken_valid, taken, mTaken);
      end
    end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      setInputs(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                bit'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                bit'($urandom_range(0, 2) != 0),
                bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 7) == 0));
      #1;
      assertCount++;
      if (cond_ready !== (!mValid || taken_ready)) begin
        failCount++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", i, cond_ready, (!mValid || taken_ready));
      end
      clockEdge();
      assertCount++;
      if (psr !== mPsr || taken_valid !== mValid || (mValid && taken !== mTaken)) begin
        failCount++;
        $display("[TB] FAIL rnd_state cyc %0d got psr=%b v=%b t=%b want psr=%b v=%b t=%b",
                 i, psr, taken_valid, taken, mPsr, mValid, mTaken);
      end
    end
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
  endtask

  task automatic test_async_reset();
    setInputs(1, 14, 1, 5'b11111, 5'b11111, 0, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b1 || psr !== 5'b11111) begin
      failCount++; $display("[TB] FAIL areset_setup got v=%b psr=%b want v=1 psr=11111", taken_valid, psr);
    end
    setInputs(0, 0, 0, 5'b0, 5'b0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    assertCount++;
    if (taken_valid !== 1'b0 || psr !== 5'b0 || taken !== 1'b0 || cond_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL areset_immediate got v=%b psr=%b t=%b rdy=%b want 0 00000 0 1", taken_valid, psr, taken, cond_ready);
    end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    setInputs(0, 0, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b0) begin failCount++; $display("[TB] FAIL areset_dropped got %b want 0", taken_valid); end
    setInputs(1, 1, 0, 5'b0, 5'b0, 1, 0, 0);
    clockEdge();
    assertCount++;
    if (taken_valid !== 1'b1 || taken !== 1'b1) begin
      failCount++; $display("[TB] FAIL areset_resume got v=%b t=%b want v=1 t=1", taken_valid, taken);
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_cmpu_mask();
    test_forwarding();
    test_backpressure();
    test_shadow();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
